prbs31_checker: RTL and testbench

//   Serial PRBS31 receiver/checker (x^31 + x^28 + 1), the far end of the on-chip PRBS31 generator.

---
 rtl/prbs31_checker.sv | 140 ++++++++++++++
 tb/tb_prbs31_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/prbs31_checker.sv
// Serial PRBS31 (x^31 + x^28 + 1) checker.
// Self-synchronises to the received bit stream, declares lock after a run of
// correct predictions, then counts bit errors against a free-running
// reference and drops lock when too many errors arrive in one window.
module prbs31_checker #(
  parameter int LOCK_COUNT  = 64,
  parameter int LOSS_WINDOW = 256,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,     // active-high despite the name
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic [1:0]       sync_state,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int MC_W  = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
  localparam int WE_W  = $clog2(LOSS_THRESH + 1);

  localparam logic [MC_W-1:0]  MATCH_LAST = MC_W'(LOCK_COUNT - 1);
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(LOSS_WINDOW - 1);
  localparam logic [WE_W-1:0]  ERR_LIMIT  = WE_W'(LOSS_THRESH);
  localparam logic [4:0]       FILL_LAST  = 5'd30;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [30:0]      hist, hist_nxt;
  logic [4:0]       fill_cnt, fill_nxt;
  logic [MC_W-1:0]  match_cnt, match_nxt;
  logic [WIN_W-1:0] win_cnt, win_cnt_nxt;
  logic [WE_W-1:0]  win_err, win_err_nxt, win_err_inc;
  logic [ERR_W-1:0] cnt_nxt;
  logic             pred;
  logic             bit_err;

  // Saturating increment for the error counter.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    sat_inc = (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign pred        = hist[27] ^ hist[30];
  assign win_err_inc = win_err + 1'b1;
  assign locked      = (state == ST_LOCKED);
  assign sync_state  = state;

  // Next-state, history and counter update for one sampled bit.
  always_comb begin
    state_nxt   = state;
    hist_nxt    = hist;
    fill_nxt    = fill_cnt;
    match_nxt   = match_cnt;
    win_cnt_nxt = win_cnt;
    win_err_nxt = win_err;
    bit_err     = 1'b0;
    if (bit_valid) begin
      case (state)
        ST_SEARCH: begin
          hist_nxt = {hist[29:0], bit_in};
          if (fill_cnt == FILL_LAST) begin
            fill_nxt  = '0;
            state_nxt = ST_VERIFY;
          end else begin
            fill_nxt = fill_cnt + 1'b1;
          end
        end
        ST_VERIFY: begin
          // Keep loading received bits so the predictor self-synchronises;
          // an all-zero history predicts zeros forever and must not lock.
          hist_nxt = {hist[29:0], bit_in};
          if ((bit_in == pred) && (hist != '0)) begin
            if (match_cnt == MATCH_LAST) begin
              match_nxt = '0;
              state_nxt = ST_LOCKED;
            end else begin
              match_nxt = match_cnt + 1'b1;
            end
          end else begin
            match_nxt = '0;
          end
        end
        ST_LOCKED: begin
          // Free-running reference: a flipped input bit costs exactly one error.
          hist_nxt    = {hist[29:0], pred};
          bit_err     = bit_in ^ pred;
          win_cnt_nxt = (win_cnt == WIN_LAST) ? '0 : win_cnt + 1'b1;
          if (bit_err && (win_err_inc == ERR_LIMIT)) begin
            state_nxt   = ST_SEARCH;
            fill_nxt    = '0;
            match_nxt   = '0;
            win_cnt_nxt = '0;
            win_err_nxt = '0;
          end else if (win_cnt == WIN_LAST) begin
            win_err_nxt = '0;
          end else if (bit_err) begin
            win_err_nxt = win_err_inc;
          end
        end
        default: state_nxt = ST_SEARCH;
      endcase
    end
    // Clear first, then count, so a coincident error survives the clear.
    cnt_nxt = clr_cnt ? '0 : err_count;
    if (bit_err) cnt_nxt = sat_inc(cnt_nxt);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= ST_SEARCH;
      hist      <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      hist      <= hist_nxt;
      fill_cnt  <= fill_nxt;
      match_cnt <= match_nxt;
      win_cnt   <= win_cnt_nxt;
      win_err   <= win_err_nxt;
      err_pulse <= bit_err;
      err_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_prbs31_checker.sv
// Testbench for prbs31_checker: default instance plus a narrow-counter
// instance (ERR_W=4, threshold equal to window) sharing the same stimulus.
module tb_prbs31_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, bit_in, bit_valid, clr_cnt;
  logic        locked_a, pulse_a;
  logic [1:0]  state_a;
  logic [15:0] cnt_a;
  logic        locked_b, pulse_b;
  logic [1:0]  state_b;
  logic [3:0]  cnt_b;

  prbs31_checker dut_a (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .clr_cnt(clr_cnt), .locked(locked_a), .sync_state(state_a),
    .err_pulse(pulse_a), .err_count(cnt_a)
  );

  prbs31_checker #(
    .LOCK_COUNT(64), .LOSS_WINDOW(256), .LOSS_THRESH(256), .ERR_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .clr_cnt(clr_cnt), .locked(locked_b), .sync_state(state_b),
    .err_pulse(pulse_b), .err_count(cnt_b)
  );

  int total = 0;
  int bad   = 0;
  logic [30:0] gen;

  typedef struct {
    logic        v;
    logic        inv;
    logic        clr;
    logic        exp_lock;
    logic [1:0]  exp_state;
    logic        exp_pulse;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_prbs(output logic b);
    b   = gen[27] ^ gen[30];
    gen = {gen[29:0], b};
  endtask

  task automatic step(input logic b, input logic v, input logic c);
    @(negedge clk);
    bit_in    = b;
    bit_valid = v;
    clr_cnt   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_prbs(input logic inv);
    logic b;
    next_prbs(b);
    step(b ^ inv, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    bit_valid = 1'b0;
    clr_cnt   = 1'b0;
    bit_in    = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    gen   = 31'd1;
  endtask

  initial begin
    logic seen;
    logic b;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 16'd1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 16'd1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 16'd1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 16'd2};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 16'd2};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 16'd0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 16'd1};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 16'd1};

    rst_n = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clr_cnt = 1'b0;
    gen = 31'd1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", locked_a, 0);
    check("rst_state", state_a, 0);
    check("rst_pulse", pulse_a, 0);
    check("rst_count", cnt_a, 0);
    @(negedge clk);
    rst_n = 1'b0;

    // Clean stream: lock on the 95th valid bit, then 10000 error-free bits.
    for (int i = 1; i <= 94; i++) send_prbs(1'b0);
    check("t1_lock_at_94", locked_a, 0);
    check("t1_state_at_94", state_a, 1);
    send_prbs(1'b0);
    check("t1_lock_at_95", locked_a, 1);
    check("t1_state_at_95", state_a, 2);
    seen = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      send_prbs(1'b0);
      seen = seen | pulse_a;
    end
    check("t1_no_pulse", seen, 0);
    check("t1_count", cnt_a, 0);
    check("t1_still_locked", locked_a, 1);

    // Locked-state error/clear sequence from the vector table.
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].v) begin
        next_prbs(b);
        step(b ^ tbl[i].inv, 1'b1, tbl[i].clr);
      end else begin
        step(1'b1, 1'b0, tbl[i].clr);
      end
      check($sformatf("t3_lock[%0d]", i), locked_a, tbl[i].exp_lock);
      check($sformatf("t3_state[%0d]", i), state_a, tbl[i].exp_state);
      check($sformatf("t3_pulse[%0d]", i), pulse_a, tbl[i].exp_pulse);
      check($sformatf("t3_cnt[%0d]", i), cnt_a, tbl[i].exp_cnt);
    end

    // Constant zero stream never locks.
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0);
    check("t2_state_at_30", state_a, 0);
    step(1'b0, 1'b1, 1'b0);
    check("t2_state_at_31", state_a, 1);
    for (int i = 0; i < 969; i++) step(1'b0, 1'b1, 1'b0);
    check("t2_state_end", state_a, 1);
    check("t2_locked_end", locked_a, 0);

    // Loss of lock after 8 errors in a window, relock, 7 errors tolerated.
    do_reset();
    for (int i = 0; i < 95; i++) send_prbs(1'b0);
    check("t4_locked", locked_a, 1);
    for (int k = 0; k < 7; k++) begin
      send_prbs(1'b1);
      repeat (9) send_prbs(1'b0);
    end
    check("t4_locked_after_7", locked_a, 1);
    send_prbs(1'b1);
    check("t4_loss_locked", locked_a, 0);
    check("t4_loss_state", state_a, 0);
    check("t4_loss_pulse", pulse_a, 1);
    check("t4_loss_count", cnt_a, 8);
    for (int i = 0; i < 94; i++) send_prbs(1'b0);
    check("t4_relock_94", locked_a, 0);
    send_prbs(1'b0);
    check("t4_relock_95", locked_a, 1);
    for (int k = 0; k < 7; k++) begin
      send_prbs(1'b1);
      repeat (4) send_prbs(1'b0);
    end
    repeat (300) send_prbs(1'b0);
    check("t4_seven_locked", locked_a, 1);
    check("t4_seven_count", cnt_a, 15);

    // Sparse valid (1 in 3) and clear coincident with an error.
    do_reset();
    for (int i = 1; i <= 95; i++) begin
      send_prbs(1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      if (i == 94) check("t5_lock_at_94", locked_a, 0);
      if (i == 95) check("t5_lock_at_95", locked_a, 1);
    end
    send_prbs(1'b1);
    check("t5_err1_pulse", pulse_a, 1);
    check("t5_err1_count", cnt_a, 1);
    step(1'b1, 1'b0, 1'b0);
    check("t5_gap_pulse", pulse_a, 0);
    step(1'b0, 1'b0, 1'b0);
    next_prbs(b);
    step(~b, 1'b1, 1'b1);
    check("t5_clr_err_pulse", pulse_a, 1);
    check("t5_clr_err_count", cnt_a, 1);
    step(1'b0, 1'b0, 1'b1);
    check("t5_clr_gap_count", cnt_a, 0);

    // Saturation on the 4-bit instance, then asynchronous reset mid-lock.
    do_reset();
    for (int i = 0; i < 95; i++) send_prbs(1'b0);
    check("t6_locked_b", locked_b, 1);
    for (int k = 0; k < 20; k++) begin
      send_prbs(1'b1);
      send_prbs(1'b0);
    end
    check("t6_sat_count", cnt_b, 15);
    check("t6_sat_locked", locked_b, 1);
    send_prbs(1'b1);
    check("t6_pre_rst_pulse", pulse_b, 1);
    #2;
    rst_n = 1'b1;
    #1;
    check("t6_rst_locked_b", locked_b, 0);
    check("t6_rst_state_b", state_b, 0);
    check("t6_rst_pulse_b", pulse_b, 0);
    check("t6_rst_count_b", cnt_b, 0);
    check("t6_rst_count_a", cnt_a, 0);
    @(negedge clk);
    rst_n = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
